axi4lite_reg_slave: RTL
=======================

# axi4lite_reg_slave

AXI4-Lite responder presenting a bank of `NUM_REGS` read/write registers of `axi4_data_size` bits. It terminates the AXI4-Lite master port of the AXI4→AXI4-Lite bridge and gives the bridge a deterministic target for bring-up and verification. All register contents are also exported as a flat bus for direct hardware use. AW and W channels are buffered independently, so they may arrive in either order.

## Interface
- `axi4_addr_size`, 32: address width.
- `axi4_data_size`, 64: data width; must be 32 or 64.
- `NUM_REGS`, 16: register count; power of two, 2–256.
- `clk` in 1: the single clock.
- `rst` in 1: reset, **synchronous, active-high**. This polarity and synchronicity are fixed.
- `s_axi4lite_aw_valid` / `_aw_ready` in / out 1: write address handshake.
- `s_axi4lite_aw_addr` in `axi4_addr_size`: byte address.
- `s_axi4lite_aw_prot` in 3: protection attributes.
- `s_axi4lite_w_valid` / `_w_ready` in / out 1: write data handshake.
- `s_axi4lite_w_data` in `axi4_data_size`: write data.
- `s_axi4lite_w_strb` in `axi4_data_size/8`: byte enables.
- `s_axi4lite_b_valid` / `_b_ready` out / in 1: write response handshake.
- `s_axi4lite_b_resp` out 2: write response; OKAY = 2'b00, SLVERR = 2'b10.
- `s_axi4lite_ar_valid` / `_ar_ready` in / out 1: read address handshake.
- `s_axi4lite_ar_addr` in `axi4_addr_size`: byte address.
- `s_axi4lite_ar_prot` in 3: protection attributes.
- `s_axi4lite_r_valid` / `_r_ready` out / in 1: read data handshake.
- `s_axi4lite_r_data` out `axi4_data_size`: read data.
- `s_axi4lite_r_resp` out 2: read response.
- `reg_q` out `NUM_REGS*axi4_data_size`: all register contents; register i occupies slice i.

## Operation
**Address decode**
- Byte lanes: BL = `axi4_data_size/8`.
- Index = `addr[log2(BL) +: log2(NUM_REGS)]`. Low `log2(BL)` address bits are ignored.
- In range iff `addr < NUM_REGS*BL`; otherwise the access is out of range.

**Write path**
- AW buffer and W buffer each hold one entry, with flags `aw_full` and `w_full`.
- `aw_ready = ~aw_full`; `w_ready = ~w_full`.
- States:
  - WR_COLLECT: when both buffers are full, move to WR_RESP at the next edge.
  - WR_RESP: `b_valid`=1. On `b_ready`, return to WR_COLLECT.
- On the COLLECT→RESP edge:
  - If in range: update each byte of the register that has `strb[k]`=1; other bytes hold.
  - Set `b_resp` = OKAY if in range, else SLVERR. An out-of-range write modifies nothing.
  - Clear both buffer flags.
- New AW/W may be accepted while in WR_RESP. They commit only after returning to WR_COLLECT.
- `strb` = 0 in range: no register change, OKAY.

**Read path**
- States:
  - RD_IDLE: `ar_ready`=1. On handshake, capture `r_data`/`r_resp` and go to RD_RESP.
  - RD_RESP: `ar_ready`=0, `r_valid`=1. On `r_ready`, return to RD_IDLE.
- Out-of-range read: `r_data`=0, `r_resp`=SLVERR.
- `r_data` and `r_resp` hold stable while `r_valid`=1 and `r_ready`=0.

**Read and write to the same register at the same edge**
- The read returns the pre-write value.

**Reset**
- All registers, `reg_q`, `r_data` = 0.
- `b_valid`, `r_valid` = 0; `b_resp`, `r_resp` = 2'b00.
- `aw_ready`, `w_ready`, `ar_ready` = 1 from the first cycle after reset.
- Buffers cleared; both FSMs return to their idle states.
- Reset mid-transaction abandons the transaction with no response and no register update.

## Timing
- Write, AW and W handshaken in cycle N (same or different cycles; N is the later one):
  - Both flags full in N+1.
  - Register, `reg_q` and `b_valid` update at the end of N+1; `b_valid` high in N+2.
- Peak write throughput with `b_ready` held at 1: one write per 2 cycles.
- Read, AR handshake in cycle N: `r_valid` high in N+1. Peak read throughput: one read per 2 cycles.
- Read and write paths are fully independent and may complete in the same cycle.
- All outputs are registered or are functions of registered flags only. There is no combinational input→output path.

## Configuration
- `AXI4LITE_REG_SLAVE_PROT_EN` defined:
  - Any access with `prot[0]`=0 (unprivileged) is rejected with SLVERR.
  - Rejected writes modify nothing; rejected reads return `r_data`=0.
- Undefined: `aw_prot`/`ar_prot` are ignored.

## Test plan
- Reset, then idle: `aw_ready`/`w_ready`/`ar_ready`=1, `b_valid`/`r_valid`=0, `reg_q`=0.
- W handshake in cycle 0, AW (addr 0x08, data 0x1122334455667788, strb 0xFF) in cycle 3:
  - Reg 1 updated and `b_valid`=1, OKAY, in cycle 5.
  - Read of 0x08 returns 0x1122334455667788.
- Partial strobe: write 0xFFFF…FF strb 0x0F to reg 2 (held 0):
  - Reg 2 = 0x00000000FFFFFFFF.
  - Write with strb 0x00 leaves it unchanged, OKAY.
- Out of range (addr 0x80, NUM_REGS=16, 64-bit):
  - Write → SLVERR, `reg_q` unchanged.
  - Read → SLVERR, `r_data`=0.
- Backpressure:
  - `b_ready`=0 for 10 cycles: `b_valid`/`b_resp` stable. A second AW/W is accepted but not committed until the first B completes.
  - `r_ready`=0: `r_data` stable and `ar_ready`=0.
- Same-edge read and write of reg 3 (old 0x5, new 0xA): `r_data`=0x5, `reg_q` slice 3 = 0xA. With `AXI4LITE_REG_SLAVE_PROT_EN`, a `prot`=3'b000 write → SLVERR, no update.

Source files
------------

// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave: AXI4-Lite register bank with NUM_REGS registers of
// axi4_data_size bits. AW and W are buffered independently, so either can
// arrive first. All register contents are also exported flat on reg_q.
// Optional build macro: AXI4LITE_REG_SLAVE_PROT_EN. When defined, any access
// with prot[0]=0 (unprivileged) is rejected with SLVERR.
module axi4lite_reg_slave #(
    parameter int axi4_addr_size = 32,
    parameter int axi4_data_size = 64,
    parameter int NUM_REGS       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_axi4lite_aw_valid,
    output logic                               s_axi4lite_aw_ready,
    input  logic [axi4_addr_size-1:0]          s_axi4lite_aw_addr,
    input  logic [2:0]                         s_axi4lite_aw_prot,
    input  logic                               s_axi4lite_w_valid,
    output logic                               s_axi4lite_w_ready,
    input  logic [axi4_data_size-1:0]          s_axi4lite_w_data,
    input  logic [axi4_data_size/8-1:0]        s_axi4lite_w_strb,
    output logic                               s_axi4lite_b_valid,
    input  logic                               s_axi4lite_b_ready,
    output logic [1:0]                         s_axi4lite_b_resp,
    input  logic                               s_axi4lite_ar_valid,
    output logic                               s_axi4lite_ar_ready,
    input  logic [axi4_addr_size-1:0]          s_axi4lite_ar_addr,
    input  logic [2:0]                         s_axi4lite_ar_prot,
    output logic                               s_axi4lite_r_valid,
    input  logic                               s_axi4lite_r_ready,
    output logic [axi4_data_size-1:0]          s_axi4lite_r_data,
    output logic [1:0]                         s_axi4lite_r_resp,
    output logic [NUM_REGS*axi4_data_size-1:0] reg_q
);

    localparam int BL    = axi4_data_size / 8;
    localparam int BL_W  = $clog2(BL);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [axi4_addr_size-1:0] ADDR_LIMIT = axi4_addr_size'(NUM_REGS * BL);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic                      aw_full_reg;
    logic [axi4_addr_size-1:0] aw_addr_reg;
    logic                      w_full_reg;
    logic [axi4_data_size-1:0] w_data_reg;
    logic [BL-1:0]             w_strb_reg;
    logic [1:0]                b_resp_reg;
    logic [axi4_data_size-1:0] r_data_reg;
    logic [1:0]                r_resp_reg;
    logic [axi4_data_size-1:0] regs_reg [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic             wr_ok, rd_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign aw_hs  = s_axi4lite_aw_valid && !aw_full_reg;
    assign w_hs   = s_axi4lite_w_valid && !w_full_reg;
    assign ar_hs  = s_axi4lite_ar_valid && (rd_state_reg == RD_IDLE);
    // A write commits only from COLLECT, so entries accepted during RESP wait.
    assign commit = (wr_state_reg == WR_COLLECT) && aw_full_reg && w_full_reg;
    assign wr_idx = aw_addr_reg[BL_W +: IDX_W];
    assign rd_idx = s_axi4lite_ar_addr[BL_W +: IDX_W];

`ifdef AXI4LITE_REG_SLAVE_PROT_EN
    logic aw_priv_reg;
    logic unused_prot;
    assign unused_prot = ^{s_axi4lite_aw_prot[2:1], s_axi4lite_ar_prot[2:1]};
    assign wr_ok = (aw_addr_reg < ADDR_LIMIT) && aw_priv_reg;
    assign rd_ok = (s_axi4lite_ar_addr < ADDR_LIMIT) && s_axi4lite_ar_prot[0];

    // Remember the privilege bit alongside the buffered write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_priv_reg <= 1'b0;
        end else if (aw_hs) begin
            aw_priv_reg <= s_axi4lite_aw_prot[0];
        end
    end
`else
    logic unused_prot;
    assign unused_prot = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot};
    assign wr_ok = (aw_addr_reg < ADDR_LIMIT);
    assign rd_ok = (s_axi4lite_ar_addr < ADDR_LIMIT);
`endif

    // State registers for the independent write and read FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_reg <= WR_COLLECT;
            rd_state_reg <= RD_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    // Write FSM next state: collect both halves, then hold B until accepted.
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_COLLECT: if (commit) wr_state_next = WR_RESP;
            WR_RESP:    if (s_axi4lite_b_ready) wr_state_next = WR_COLLECT;
            default:    wr_state_next = WR_COLLECT;
        endcase
    end

    // Read FSM next state: one outstanding read, held until R is accepted.
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE: if (s_axi4lite_ar_valid) rd_state_next = RD_RESP;
            RD_RESP: if (s_axi4lite_r_ready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // AW and W single-entry buffers; both flags drop on the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full_reg <= 1'b1;
                    aw_addr_reg <= s_axi4lite_aw_addr;
                end
                if (w_hs) begin
                    w_full_reg <= 1'b1;
                    w_data_reg <= s_axi4lite_w_data;
                    w_strb_reg <= s_axi4lite_w_strb;
                end
            end
        end
    end

    // Register bank: byte-masked update on commit when the write is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int k = 0; k < BL; k++) begin
                if (w_strb_reg[k]) begin
                    regs_reg[wr_idx][k*8 +: 8] <= w_data_reg[k*8 +: 8];
                end
            end
        end
    end

    // Write response code captured on the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_resp_reg <= RESP_OKAY;
        end else if (commit) begin
            b_resp_reg <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Read data capture; sampling the bank before its update gives old data
    // when a read and a write to the same register share an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_reg <= '0;
            r_resp_reg <= RESP_OKAY;
        end else if (ar_hs) begin
            r_data_reg <= rd_ok ? regs_reg[rd_idx] : '0;
            r_resp_reg <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Flat export of every register.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
            assign reg_q[gi*axi4_data_size +: axi4_data_size] = regs_reg[gi];
        end
    endgenerate

    assign s_axi4lite_aw_ready = !aw_full_reg;
    assign s_axi4lite_w_ready  = !w_full_reg;
    assign s_axi4lite_b_valid  = (wr_state_reg == WR_RESP);
    assign s_axi4lite_b_resp   = b_resp_reg;
    assign s_axi4lite_ar_ready = (rd_state_reg == RD_IDLE);
    assign s_axi4lite_r_valid  = (rd_state_reg == RD_RESP);
    assign s_axi4lite_r_data   = r_data_reg;
    assign s_axi4lite_r_resp   = r_resp_reg;

endmodule
